// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared definitions for the instruction sequencer:
//   - opcode encodings (instruction bits 15:13)
//   - step-counter encodings presented to the control unit as current_state
//   - sequencer FSM state type
//   - is_legal_op(): screens out the undefined opcodes 011 and 110
// -----------------------------------------------------------------------------
package instr_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NAN = 3'b010;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_REP = 3'b111;

  localparam logic [1:0] STEP_DECODE = 2'b00;
  localparam logic [1:0] STEP_LOAD_A = 2'b01;
  localparam logic [1:0] STEP_ALU    = 2'b10;
  localparam logic [1:0] STEP_WRITE  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NAN, OP_OUT, OP_LDI, OP_REP: is_legal_op = 1'b1;
      default:                                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous first-word-fall-through FIFO holding queued instructions.
// A word written on one edge appears at head from the next cycle (no bypass).
// Push while full and pop while empty are ignored.
// Ports:
//   clock, resetn      clock; asynchronous active-low reset (flushes FIFO)
//   push, wdata        enqueue request and data
//   pop                dequeue the current head
//   head               oldest stored word (valid when !empty)
//   count              occupancy, 0..DEPTH
//   full, empty        occupancy flags
// -----------------------------------------------------------------------------
module instr_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, so clearing the data costs logic and
  // buys nothing.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Front-end scheduler for the 4-step control unit. Queues incoming instruction
// words, discards undefined opcodes, and steps each legal instruction through
// current_state 00 -> 01 -> 10 -> 11. Back-to-back legal instructions chain
// with no idle gap.
// Optional build macro INSTR_SEQ_SINGLE_STEP_EN: adds step_req; an instruction
// starts only from IDLE on a cycle with step_req=1, and every instruction
// returns to IDLE after step 11.
// Ports:
//   clock, resetn       clock; asynchronous active-low reset
//   step_req            (INSTR_SEQ_SINGLE_STEP_EN only) single-step request
//   in_instr, in_valid  instruction word and its valid strobe
//   in_ready            FIFO can accept a word (count < DEPTH)
//   run                 permission to start new instructions
//   stall               freezes the step counter while high
//   instruction         instruction currently executing
//   current_state       step counter for the control unit
//   busy                high while executing
//   done                one-cycle pulse per retired instruction
//   illegal_instr       one-cycle pulse per discarded instruction
//   fifo_count          FIFO occupancy
//   retired_count       retired instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic             step_req,
`endif
  input  logic [15:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             run,
  input  logic             stall,
  output logic [15:0]      instruction,
  output logic [1:0]       current_state,
  output logic             busy,
  output logic             done,
  output logic             illegal_instr,
  output logic [CW-1:0]    fifo_count,
  output logic [CNT_W-1:0] retired_count
);

  seq_state_t  state;
  logic [15:0] head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        head_legal;
  logic        finishing;
  logic        start_gate;
  logic        chain_en;
  logic [1:0]  step_next;

  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head_legal = is_legal_op(head[15:13]);
  assign finishing  = (state == EXEC) && (current_state == STEP_WRITE) && !stall;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
  // step_req only matters in IDLE, so pulses seen while busy fall away.
  assign start_gate = step_req;
  assign chain_en   = 1'b0;
`else
  assign start_gate = 1'b1;
  assign chain_en   = 1'b1;
`endif

  // The head is popped whether or not it is legal: a legal word is loaded,
  // an illegal one is dropped in the same cycle.
  always_comb begin
    pop = 1'b0;
    if (run && !fifo_empty) begin
      if (state == IDLE) pop = start_gate;
      else               pop = finishing && chain_en;
    end
  end

  always_comb begin
    step_next = STEP_DECODE;
    case (current_state)
      STEP_DECODE: step_next = STEP_LOAD_A;
      STEP_LOAD_A: step_next = STEP_ALU;
      STEP_ALU:    step_next = STEP_WRITE;
      default:     step_next = STEP_DECODE;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .wdata  (in_instr),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      instruction   <= '0;
      current_state <= STEP_DECODE;
      busy          <= 1'b0;
      done          <= 1'b0;
      illegal_instr <= 1'b0;
      retired_count <= '0;
    end else begin
      // NOTE: pulse outputs get a non-blocking default here and are raised
      // below; the last non-blocking write in the block wins, so each pulse
      // lasts exactly one cycle without extra clear logic.
      done          <= 1'b0;
      illegal_instr <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_legal) begin
              instruction   <= head;
              current_state <= STEP_DECODE;
              state         <= EXEC;
              busy          <= 1'b1;
            end else begin
              illegal_instr <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (!stall) begin
            if (current_state != STEP_WRITE) begin
              current_state <= step_next;
            end else begin
              done          <= 1'b1;
              retired_count <= retired_count + CNT_W'(1);
              current_state <= STEP_DECODE;
              if (pop && head_legal) begin
                instruction <= head;
              end else begin
                state         <= IDLE;
                busy          <= 1'b0;
                illegal_instr <= pop;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed scenarios followed by a randomized run of instr_sequencer (default
// build), compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock    = 1'b0;
  logic             resetn   = 1'b0;
  logic [15:0]      in_instr = '0;
  logic             in_valid = 1'b0;
  logic             run      = 1'b0;
  logic             stall    = 1'b0;
  logic             in_ready;
  logic [15:0]      instruction;
  logic [1:0]       current_state;
  logic             busy;
  logic             done;
  logic             illegal_instr;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] retired_count;

  instr_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .in_instr      (in_instr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .run           (run),
    .stall         (stall),
    .instruction   (instruction),
    .current_state (current_state),
    .busy          (busy),
    .done          (done),
    .illegal_instr (illegal_instr),
    .fifo_count    (fifo_count),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending words plus "is something running,
  // and which of its four steps is it on".
  logic [15:0]      q[$];
  bit               m_active;
  int               m_step;
  logic [15:0]      m_instr;
  bit               m_done;
  bit               m_ill;
  logic [CNT_W-1:0] m_retired;

  int done_seen;
  int ill_seen;
  int busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [15:0] w);
    return !(w[15:13] == 3'd3 || w[15:13] == 3'd6);
  endfunction

  task automatic model_reset();
    q.delete();
    m_active  = 0;
    m_step    = 0;
    m_instr   = '0;
    m_done    = 0;
    m_ill     = 0;
    m_retired = '0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge occupancy.
  task automatic model_edge();
    bit          take;
    bit          accept;
    logic [15:0] h;
    if (!resetn) begin
      model_reset();
      return;
    end
    accept = in_valid && (q.size() < DEPTH);
    m_done = 0;
    m_ill  = 0;
    take   = 0;
    if (!m_active) begin
      take = run && (q.size() > 0);
    end else if (!stall) begin
      if (m_step == 3) begin
        m_done    = 1;
        m_retired = m_retired + 1'b1;
        m_active  = 0;
        m_step    = 0;
        take      = run && (q.size() > 0);
      end else begin
        m_step++;
      end
    end
    if (take) begin
      h = q.pop_front();
      if (legal(h)) begin
        m_instr  = h;
        m_active = 1;
        m_step   = 0;
      end else begin
        m_ill = 1;
      end
    end
    if (accept) q.push_back(in_instr);
  endtask

  task automatic compare_all();
    chk("in_ready",      32'(in_ready),      32'(q.size() < DEPTH));
    chk("fifo_count",    32'(fifo_count),    32'(q.size()));
    chk("instruction",   32'(instruction),   32'(m_instr));
    chk("current_state", 32'(current_state), 32'(m_step));
    chk("busy",          32'(busy),          32'(m_active));
    chk("done",          32'(done),          32'(m_done));
    chk("illegal_instr", 32'(illegal_instr), 32'(m_ill));
    chk("retired_count", 32'(retired_count), 32'(m_retired));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
      done_seen += int'(done);
      ill_seen  += int'(illegal_instr);
      busy_seen += int'(busy);
    end
  endtask

  task automatic clear_seen();
    done_seen = 0;
    ill_seen  = 0;
    busy_seen = 0;
  endtask

  initial begin
    bit found;
    model_reset();
    clear_seen();

    // Reset state
    #2;
    compare_all();
    @(negedge clock);
    resetn = 1'b1;

    // Single ADD runs through four steps
    run = 1'b1;
    in_instr = 16'h0380; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_seen();
    tick(7);
    chk("s1_done_pulses", 32'(done_seen), 32'd1);
    chk("s1_retired", 32'(retired_count), 32'd1);

    // Three legal words execute back-to-back
    clear_seen();
    in_valid = 1'b1;
    in_instr = 16'h0000; tick();
    in_instr = 16'h2080; tick();
    in_instr = 16'hA005; tick();
    in_valid = 1'b0;
    tick(14);
    chk("s2_busy_cycles", 32'(busy_seen), 32'd12);
    chk("s2_done_pulses", 32'(done_seen), 32'd3);
    chk("s2_retired", 32'(retired_count), 32'd4);

    // Illegal opcode is discarded, the next word executes
    clear_seen();
    in_valid = 1'b1;
    in_instr = 16'h6000; tick();
    in_instr = 16'h8000; tick();
    in_valid = 1'b0;
    tick(8);
    chk("s3_illegal_pulses", 32'(ill_seen), 32'd1);
    chk("s3_done_pulses", 32'(done_seen), 32'd1);
    chk("s3_last_instr", 32'(instruction), 32'h8000);
    chk("s3_retired", 32'(retired_count), 32'd5);

    // Fill past capacity with run low, then drain
    run = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_instr = 16'h2000 | 16'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("s4_full_in_ready", 32'(in_ready), 32'd0);
    chk("s4_full_count", 32'(fifo_count), 32'(DEPTH));
    run = 1'b1;
    tick(4 * DEPTH + 2);
    chk("s4_drained_count", 32'(fifo_count), 32'd0);
    chk("s4_retired", 32'(retired_count), 32'd13);
    chk("s4_last_instr", 32'(instruction), 32'h2007);

    // Stall for three cycles in step 10
    in_instr = 16'hA005; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (current_state == 2'b10) found = 1;
    end
    chk("s5_reach_step10", 32'(found), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_hold_step10", 32'(current_state), 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("s5_step11", 32'(current_state), 32'd3);
    chk("s5_no_early_done", 32'(done), 32'd0);
    tick();
    chk("s5_done_late", 32'(done), 32'd1);

    // Asynchronous reset mid-instruction with words queued
    in_valid = 1'b1;
    in_instr = 16'h0380; tick();
    in_instr = 16'h2080; tick();
    in_instr = 16'hA005; tick();
    in_valid = 1'b0;
    chk("s6_pre_step01", 32'(current_state), 32'd1);
    chk("s6_pre_queued", 32'(fifo_count), 32'd2);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("s6_async_busy", 32'(busy), 32'd0);
    tick();
    resetn = 1'b1;
    clear_seen();
    tick(8);
    chk("s6_no_done", 32'(done_seen), 32'd0);
    chk("s6_retired", 32'(retired_count), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_instr = 16'($urandom);
      run      = ($urandom_range(0, 9) < 8);
      stall    = ($urandom_range(0, 9) < 2);
      tick();
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    run      = 1'b1;
    tick(4 * DEPTH + 4);
    chk("rand_drained", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
